mdu_seq: RTL and testbench

- Iterative multiply/divide sequencer for the multi-cycle core.
- Owns no arithmetic of its own. Every add, subtract and negate is issued to one external shared 33-bit adder (a + b + cin -> {cout, sum}) through its adder port.
- Sits beside the ALU in the EX stage. The core controller pulses start and stalls until done.

---
 rtl/mdu_seq.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mdu_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide sequencer.
//
// Runs shift-add multiplication and restoring division one bit per clock.
// It has no arithmetic of its own: every add, subtract and negate goes
// through an external shared (XLEN+1)-bit adder on the add_* port.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               abort the current op (only when MDU_ABORT_EN is defined)
//   start, op           launch request and opcode, sampled only in IDLE
//                       000 MUL, 001 MULH, 010 MUL, 011 MULHU,
//                       100 DIV, 101 DIVU, 110 REM, 111 REMU
//   src_a, src_b        multiplicand/dividend and multiplier/divisor
//   busy                high from the cycle after an accepted start
//                       through the done cycle
//   done, result        one-cycle completion pulse and the registered result
//   add_a, add_b,       operands and carry-in driven to the shared adder
//   add_cin
//   add_sum, add_cout   combinational result returned by the shared adder
//
// Optional feature macro: MDU_ABORT_EN (adds the flush input).
//
// Register roles:
//   multiply: hi = accumulator, lo = multiplier, opnd = multiplicand
//   divide:   hi = remainder,   lo = dividend/quotient, opnd = divisor
module mdu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef MDU_ABORT_EN
  input  logic            flush,
`endif
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN:0]   add_a,
  output logic [XLEN:0]   add_b,
  output logic            add_cin,
  input  logic [XLEN:0]   add_sum,
  input  logic            add_cout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP_A,
    S_PREP_B,
    S_ITER,
    S_FIX_LO,
    S_FIX_HI,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(XLEN - 1);

  state_t            state, state_nxt;
  logic [2:0]        op_q, op_nxt;
  logic [XLEN-1:0]   hi, hi_nxt;
  logic [XLEN-1:0]   lo, lo_nxt;
  logic [XLEN-1:0]   opnd, opnd_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              sign_a, sign_a_nxt;
  logic              sign_b, sign_b_nxt;
  logic              carry, carry_nxt;
  logic [XLEN-1:0]   result_nxt;
  logic              abort;

  logic [XLEN-1:0]   prep_x;
  logic [XLEN-1:0]   fix_x;
  logic              fix_neg;
  logic              q_div;
  logic              q_rem;
  logic              q_sel_hi;

`ifdef MDU_ABORT_EN
  assign abort = flush;
`else
  assign abort = 1'b0;
`endif

  // MULH, DIV and REM take the sign-magnitude path through PREP and FIX.
  function automatic logic is_signed_op(input logic [2:0] o);
    return (o == 3'b001) || (o == 3'b100) || (o == 3'b110);
  endfunction

  assign q_div    = op_q[2];
  assign q_rem    = op_q[2] & op_q[1];
  assign q_sel_hi = q_rem | (~op_q[2] & op_q[0]);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // State and datapath register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= '0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      cnt    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      carry  <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      op_q   <= op_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
      opnd   <= opnd_nxt;
      cnt    <= cnt_nxt;
      sign_a <= sign_a_nxt;
      sign_b <= sign_b_nxt;
      carry  <= carry_nxt;
      result <= result_nxt;
    end
  end

  // Next-state, adder drive and datapath update.
  always_comb begin
    state_nxt  = state;
    op_nxt     = op_q;
    hi_nxt     = hi;
    lo_nxt     = lo;
    opnd_nxt   = opnd;
    cnt_nxt    = cnt;
    sign_a_nxt = sign_a;
    sign_b_nxt = sign_b;
    carry_nxt  = carry;
    result_nxt = result;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    prep_x     = '0;
    fix_x      = '0;
    fix_neg    = 1'b0;

    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            op_nxt     = op;
            hi_nxt     = '0;
            sign_a_nxt = 1'b0;
            sign_b_nxt = 1'b0;
            carry_nxt  = 1'b0;
            cnt_nxt    = CNT_MAX;
            if (op[2]) begin
              opnd_nxt = src_b;
              lo_nxt   = src_a;
            end else begin
              opnd_nxt = src_a;
              lo_nxt   = src_b;
            end
            // A zero divisor short-circuits straight to DONE.
            if (op[2] && (src_b == '0)) begin
              state_nxt  = S_DONE;
              result_nxt = op[1] ? src_a : '1;
            end else if (is_signed_op(op)) begin
              state_nxt = S_PREP_A;
            end else begin
              state_nxt = S_ITER;
            end
          end
        end

        // Replace the src_a operand with its magnitude.
        S_PREP_A: begin
          prep_x     = q_div ? lo : opnd;
          add_a      = prep_x[XLEN-1] ? {1'b0, ~prep_x} : {1'b0, prep_x};
          add_cin    = prep_x[XLEN-1];
          sign_a_nxt = prep_x[XLEN-1];
          if (q_div) begin
            lo_nxt = add_sum[XLEN-1:0];
          end else begin
            opnd_nxt = add_sum[XLEN-1:0];
          end
          state_nxt = S_PREP_B;
        end

        // Replace the src_b operand with its magnitude.
        S_PREP_B: begin
          prep_x     = q_div ? opnd : lo;
          add_a      = prep_x[XLEN-1] ? {1'b0, ~prep_x} : {1'b0, prep_x};
          add_cin    = prep_x[XLEN-1];
          sign_b_nxt = prep_x[XLEN-1];
          if (q_div) begin
            opnd_nxt = add_sum[XLEN-1:0];
          end else begin
            lo_nxt = add_sum[XLEN-1:0];
          end
          cnt_nxt   = CNT_MAX;
          state_nxt = S_ITER;
        end

        S_ITER: begin
          if (q_div) begin
            // Trial subtract of the divisor from the shifted remainder;
            // bit XLEN of the sum set means the trial went negative.
            add_a   = {hi, lo[XLEN-1]};
            add_b   = ~{1'b0, opnd};
            add_cin = 1'b1;
            if (!add_sum[XLEN]) begin
              hi_nxt = add_sum[XLEN-1:0];
              lo_nxt = {lo[XLEN-2:0], 1'b1};
            end else begin
              hi_nxt = {hi[XLEN-2:0], lo[XLEN-1]};
              lo_nxt = {lo[XLEN-2:0], 1'b0};
            end
          end else begin
            // Add the multiplicand when the multiplier LSB is set, then
            // shift the whole {carry, hi, lo} pair right by one.
            add_a  = {1'b0, hi};
            add_b  = lo[0] ? {1'b0, opnd} : '0;
            hi_nxt = add_sum[XLEN:1];
            lo_nxt = {add_sum[0], lo[XLEN-1:1]};
          end
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == '0) begin
            state_nxt = is_signed_op(op_q) ? S_FIX_LO : S_DONE;
          end
        end

        // Negate via ~x + 1; the sign-extended ~{0,x} makes add_cout the
        // carry out of the low word, which FIX_HI needs for MULH.
        S_FIX_LO: begin
          fix_x   = q_rem ? hi : lo;
          fix_neg = q_rem ? sign_a : (sign_a ^ sign_b);
          add_a   = fix_neg ? ~{1'b0, fix_x} : {1'b0, fix_x};
          add_cin = fix_neg;
          if (q_rem) begin
            hi_nxt = add_sum[XLEN-1:0];
          end else begin
            lo_nxt = add_sum[XLEN-1:0];
          end
          carry_nxt = add_cout;
          state_nxt = q_div ? S_DONE : S_FIX_HI;
        end

        S_FIX_HI: begin
          fix_neg   = sign_a ^ sign_b;
          add_a     = fix_neg ? ~{1'b0, hi} : {1'b0, hi};
          add_cin   = fix_neg & carry;
          hi_nxt    = add_sum[XLEN-1:0];
          state_nxt = S_DONE;
        end

        S_DONE: begin
          state_nxt = S_IDLE;
        end

        default: begin
          state_nxt = S_IDLE;
        end
      endcase

      // Capture the result as the last working state hands over to DONE,
      // so result is already valid while done is high.
      if ((state != S_IDLE) && (state != S_DONE) && (state_nxt == S_DONE)) begin
        result_nxt = q_sel_hi ? hi_nxt : lo_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq.
// Stimulus pushes expected results into a scoreboard queue; an independent
// monitor pops and compares result and latency on every done pulse.
module tb_mdu_seq;

   typedef struct {
      string       name;
      logic [31:0] expResult;
      int          expLatency;
      int          stamp;
   } scoreEntry_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [32:0] addA;
   logic [32:0] addB;
   logic        addCin;
   logic [32:0] addSum;
   logic        addCout;
`ifdef MDU_ABORT_EN
   logic        flush;
`endif

   scoreEntry_t scoreQ[$];
   int          cycleCnt = 0;
   int          checkCount = 0;
   int          errCount = 0;

   localparam logic [2:0] OP_MUL   = 3'b000;
   localparam logic [2:0] OP_MULH  = 3'b001;
   localparam logic [2:0] OP_MUL2  = 3'b010;
   localparam logic [2:0] OP_MULHU = 3'b011;
   localparam logic [2:0] OP_DIV   = 3'b100;
   localparam logic [2:0] OP_DIVU  = 3'b101;
   localparam logic [2:0] OP_REM   = 3'b110;
   localparam logic [2:0] OP_REMU  = 3'b111;

   mdu_seq #(.XLEN(32), .CNT_W(6)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef MDU_ABORT_EN
      .flush    (flush),
`endif
      .start    (start),
      .op       (op),
      .src_a    (srcA),
      .src_b    (srcB),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .add_a    (addA),
      .add_b    (addB),
      .add_cin  (addCin),
      .add_sum  (addSum),
      .add_cout (addCout)
   );

   // Shared 33-bit adder the sequencer borrows.
   assign {addCout, addSum} = {1'b0, addA} + {1'b0, addB} + {33'd0, addCin};

   // Free-running clock and cycle counter used for latency stamps.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Compare one value against its expected value and count it.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (scoreQ.size() == 0) begin
            checkCount++;
            errCount++;
            $display("[TB] FAIL spuriousDone: got done=1 at cycle %0d expected no done", cycleCnt);
         end else begin
            scoreEntry_t e;
            e = scoreQ.pop_front();
            checkOutput({e.name, " result"}, 64'(result), 64'(e.expResult));
            checkOutput({e.name, " latency"}, 64'(cycleCnt - e.stamp), 64'(e.expLatency));
         end
      end
   end

   // Drive one start pulse at a negedge and queue its expected response.
   task automatic launch(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expRes, input int expLat);
      scoreEntry_t e;
      op    = o;
      srcA  = a;
      srcB  = b;
      start = 1'b1;
      e.name       = name;
      e.expResult  = expRes;
      e.expLatency = expLat;
      e.stamp      = cycleCnt;
      scoreQ.push_back(e);
      @(negedge clk);
      start = 1'b0;
      op    = 3'b000;
      srcA  = 32'hDEAD_BEEF;
      srcB  = 32'h1234_5678;
   endtask

   // Wait (bounded) for the scoreboard to drain, then idle a few cycles
   // so a stray second done pulse would still be seen.
   task automatic waitIdle(input int budget);
      int n = 0;
      while (scoreQ.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (scoreQ.size() != 0) begin
         checkCount++;
         errCount++;
         $display("[TB] FAIL timeout: got %0d pending results expected 0", scoreQ.size());
         scoreQ.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic applyStimulus(input string name, input logic [2:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] expRes, input int expLat);
      launch(name, o, a, b, expRes, expLat);
      waitIdle(60);
   endtask

   initial begin
      int stamp;
      rst_n = 1'b0;
      start = 1'b0;
      op    = 3'b000;
      srcA  = '0;
      srcB  = '0;
`ifdef MDU_ABORT_EN
      flush = 1'b0;
`endif
      repeat (2) @(negedge clk);

      // Reset state.
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset done", 64'(done), 64'd0);
      checkOutput("reset result", 64'(result), 64'd0);
      checkOutput("reset add_a", 64'(addA), 64'd0);
      checkOutput("reset add_b", 64'(addB), 64'd0);
      checkOutput("reset add_cin", 64'(addCin), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Multiply.
      applyStimulus("MULHU ff*ff", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      applyStimulus("MUL ff*ff",   OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
      applyStimulus("MULH -2*3",   OP_MULH,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 37);
      applyStimulus("MUL -2*3",    OP_MUL,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 33);
      applyStimulus("MUL010 7*6",  OP_MUL2,  32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 33);
      applyStimulus("MULH -1*-1",  OP_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 37);
      applyStimulus("MULH min*2",  OP_MULH,  32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 37);

      // Divide.
      applyStimulus("DIV -7/2",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 36);
      applyStimulus("REM -7/2",    OP_REM,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 36);
      applyStimulus("REM 7/-2",    OP_REM,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 36);
      applyStimulus("DIVU 100/7",  OP_DIVU,  32'd100,       32'd7,         32'd14,        33);
      applyStimulus("REMU 100/7",  OP_REMU,  32'd100,       32'd7,         32'd2,         33);

      // Divide by zero and signed overflow.
      applyStimulus("DIVU 5/0",    OP_DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      applyStimulus("REM 5/0",     OP_REM,   32'd5,         32'd0,         32'd5,         1);
      applyStimulus("DIV ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 36);
      applyStimulus("REM ovf",     OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 36);

      // Extra start pulses while busy and in the DONE cycle are ignored.
      stamp = cycleCnt;
      launch("DIVU restart", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
      while (cycleCnt < stamp + 5) @(negedge clk);
      op = OP_MUL; srcA = 32'd3; srcB = 32'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cycleCnt < stamp + 33) @(negedge clk);
      op = OP_MUL; srcA = 32'd3; srcB = 32'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitIdle(60);
      repeat (40) @(negedge clk);

      // Asynchronous reset mid-operation.
      stamp = cycleCnt;
      launch("DIVU reset", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
      while (cycleCnt < stamp + 10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("reset mid-op busy", 64'(busy), 64'd0);
      checkOutput("reset mid-op result", 64'(result), 64'd0);
      scoreQ.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      checkOutput("post-reset busy", 64'(busy), 64'd0);

`ifdef MDU_ABORT_EN
      // Flush mid-operation: no done, result unchanged.
      applyStimulus("DIVU pre-flush", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
      stamp = cycleCnt;
      launch("MULHU flush", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      while (cycleCnt < stamp + 12) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      scoreQ.delete();
      checkOutput("flush busy", 64'(busy), 64'd0);
      repeat (40) @(negedge clk);
      checkOutput("flush result held", 64'(result), 64'd14);
      applyStimulus("MULHU 3*5", OP_MULHU, 32'd3, 32'd5, 32'd0, 33);
`endif

      checkOutput("scoreboard drained", 64'(scoreQ.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
